// File: rtl/rca_seq_ctrl.sv
`timescale 1ns/1ps
// W-bit add/sub through one 4-bit ripple stage, one nibble per clock; result NIBBLES cycles after accept.
// Result is held in DONE until out_ready; no request is accepted until the controller returns to IDLE.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   sub,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [3:0]      nib_a, nib_b;
  logic [5:0]      res;
  logic            last;

  // Returns {carry into bit 3, carry out, sum[3:0]}; carries ripple bit by bit.
  function automatic logic [5:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] c;
    logic [3:0] sum;
    c = '0;
    sum = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      sum[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (y[i] & c[i]) | (c[i] & x[i]);
    end
    return {c[3], c[4], sum};
  endfunction

  assign last  = (idx == IW'(NIBBLES - 1));
  assign nib_a = a_q[{idx, 2'b00} +: 4];
  assign nib_b = b_q[{idx, 2'b00} +: 4];
  assign res   = rca4(nib_a, nib_b, carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            b_q   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
          end
        end
        RUN: begin
          s[{idx, 2'b00} +: 4] <= res[3:0];
          carry                <= res[4];
          if (last) begin
            cout <= res[4];
            ovf  <= res[5] ^ res[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
